// File: rtl/wash_pkg.sv
// Shared definitions for the washing-machine controller: phase indices,
// phase-timer scheduler state encoding and default phase durations.
package wash_pkg;

  localparam logic [1:0] PH_WASH  = 2'd0;
  localparam logic [1:0] PH_RINSE = 2'd1;
  localparam logic [1:0] PH_DRY   = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } pts_state_e;

  localparam int DEF_WASH_TICKS  = 1800;
  localparam int DEF_RINSE_TICKS = 900;
  localparam int DEF_DRY_TICKS   = 1200;

endpackage

// File: rtl/phase_timer_sched_if.sv
// Bus between the wash FSM phase logic and the shared phase-timer scheduler.
// Optional feature macro: PHASE_TIMER_PAUSE_EN adds the pause signal.
interface phase_timer_sched_if #(
  parameter int CNT_W = 12
);
  logic             tick_en;
  logic [2:0]       req;
  logic [2:0]       grant;
  logic [2:0]       done;
  logic             busy;
  logic [CNT_W-1:0] remaining;
`ifdef PHASE_TIMER_PAUSE_EN
  logic             pause;
`endif

  modport master (
    output tick_en,
    output req,
`ifdef PHASE_TIMER_PAUSE_EN
    output pause,
`endif
    input  grant,
    input  done,
    input  busy,
    input  remaining
  );

  modport slave (
    input  tick_en,
    input  req,
`ifdef PHASE_TIMER_PAUSE_EN
    input  pause,
`endif
    output grant,
    output done,
    output busy,
    output remaining
  );
endinterface

// File: rtl/phase_timer_sched_rr_arb3.sv
// Combinational 3-way round-robin arbiter; the search starts at the index
// after 'last' and wraps. Outputs are zero / don't-care when req is zero.
module rr_arb3 (
  input  logic [2:0] req,
  input  logic [1:0] last,
  output logic [2:0] gnt_onehot,
  output logic [1:0] gnt_idx
);

  // Pick the first requester in rotated priority order.
  always_comb begin
    logic [1:0] o0, o1, o2;
    logic [3:0] req4;
    req4 = {1'b0, req};
    case (last)
      2'd0:    begin o0 = 2'd1; o1 = 2'd2; o2 = 2'd0; end
      2'd1:    begin o0 = 2'd2; o1 = 2'd0; o2 = 2'd1; end
      default: begin o0 = 2'd0; o1 = 2'd1; o2 = 2'd2; end
    endcase
    if (req4[o0])      gnt_idx = o0;
    else if (req4[o1]) gnt_idx = o1;
    else               gnt_idx = o2;
    gnt_onehot = (req != 3'b000) ? (3'b001 << gnt_idx) : 3'b000;
  end

endmodule

// File: rtl/phase_timer_sched.sv
// Shared phase-timer scheduler: grants the single down-counter to one of
// WASH/RINSE/DRY round-robin, counts on tick_en and pulses done on completion.
// Optional feature macro: PHASE_TIMER_PAUSE_EN (pause holds the count).
module phase_timer_sched
  import wash_pkg::*;
#(
  parameter int CNT_W       = 12,
  parameter int WASH_TICKS  = DEF_WASH_TICKS,
  parameter int RINSE_TICKS = DEF_RINSE_TICKS,
  parameter int DRY_TICKS   = DEF_DRY_TICKS
) (
  input  logic             CLK,
  input  logic             nRESET,
  phase_timer_sched_if.slave bus
);

  if (WASH_TICKS < 1 || 64'(WASH_TICKS) >= (64'd1 << CNT_W)) begin : g_bad_wash
    $error("WASH_TICKS out of range for CNT_W");
  end
  if (RINSE_TICKS < 1 || 64'(RINSE_TICKS) >= (64'd1 << CNT_W)) begin : g_bad_rinse
    $error("RINSE_TICKS out of range for CNT_W");
  end
  if (DRY_TICKS < 1 || 64'(DRY_TICKS) >= (64'd1 << CNT_W)) begin : g_bad_dry
    $error("DRY_TICKS out of range for CNT_W");
  end

  pts_state_e       state;
  logic [2:0]       grant_r;
  logic [1:0]       gidx;
  logic [1:0]       last;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] load_val;
  logic [2:0]       arb_oh;
  logic [1:0]       arb_idx;
  logic             tick_ok;
  logic             owner_req;

  rr_arb3 u_arb (
    .req        (bus.req),
    .last       (last),
    .gnt_onehot (arb_oh),
    .gnt_idx    (arb_idx)
  );

`ifdef PHASE_TIMER_PAUSE_EN
  assign tick_ok = bus.tick_en & ~bus.pause;
`else
  assign tick_ok = bus.tick_en;
`endif

  // The granted requester is still asking; grant_r is one-hot in RUN/DONE.
  assign owner_req = |(bus.req & grant_r);

  // Duration for the phase the arbiter currently selects.
  always_comb begin
    case (arb_idx)
      PH_WASH:  load_val = CNT_W'(WASH_TICKS);
      PH_RINSE: load_val = CNT_W'(RINSE_TICKS);
      default:  load_val = CNT_W'(DRY_TICKS);
    endcase
  end

  // FSM, counter and last-served pointer; abort takes priority over the tick.
  always_ff @(posedge CLK) begin
    if (!nRESET) begin
      state   <= ST_IDLE;
      grant_r <= '0;
      gidx    <= '0;
      last    <= PH_DRY;
      cnt     <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.req != 3'b000) begin
            state   <= ST_RUN;
            grant_r <= arb_oh;
            gidx    <= arb_idx;
            cnt     <= load_val;
          end
        end
        ST_RUN: begin
          if (!owner_req) begin
            state   <= ST_IDLE;
            grant_r <= '0;
            cnt     <= '0;
            last    <= gidx;
          end else if (tick_ok && cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
            if (cnt == CNT_W'(1)) state <= ST_DONE;
          end
        end
        ST_DONE: begin
          state   <= ST_IDLE;
          grant_r <= '0;
          cnt     <= '0;
          last    <= gidx;
        end
        default: begin
          state   <= ST_IDLE;
          grant_r <= '0;
          cnt     <= '0;
        end
      endcase
    end
  end

  assign bus.grant     = grant_r;
  assign bus.done      = (state == ST_DONE) ? grant_r : 3'b000;
  assign bus.busy      = (state != ST_IDLE);
  assign bus.remaining = cnt;

endmodule

// File: tb/tb_phase_timer_sched.sv
// Self-checking bench for phase_timer_sched (WASH=3, RINSE=2, DRY=4 ticks).
// Build with PHASE_TIMER_PAUSE_EN to also exercise the pause feature.
module tb_phase_timer_sched;

  localparam int CW = 12;

  logic CLK = 1'b0;
  logic nRESET = 1'b0;
  always #5 CLK = ~CLK;

  phase_timer_sched_if #(.CNT_W(CW)) bus ();

  phase_timer_sched #(
    .CNT_W       (CW),
    .WASH_TICKS  (3),
    .RINSE_TICKS (2),
    .DRY_TICKS   (4)
  ) dut (
    .CLK    (CLK),
    .nRESET (nRESET),
    .bus    (bus)
  );

  int n_chk = 0;
  int n_fail = 0;

  // Reference: who owns the timer (-1 none), ticks left, phase finishing now.
  int dur [3] = '{3, 2, 4};
  int m_owner = -1;
  int m_rem = 0;
  int m_donep = -1;
  int m_last = 2;

  function automatic bit [2:0] ph_bit(int p);
    bit [2:0] v;
    v = '0;
    if (p >= 0) v[p] = 1'b1;
    return v;
  endfunction

  function void model_step(bit [2:0] r, bit t, bit p, bit rst);
    bit pz;
    pz = 1'b0;
`ifdef PHASE_TIMER_PAUSE_EN
    pz = p;
`endif
    if (rst) begin
      m_owner = -1; m_rem = 0; m_donep = -1; m_last = 2;
    end else if (m_donep >= 0) begin
      m_last = m_donep; m_donep = -1; m_owner = -1; m_rem = 0;
    end else if (m_owner < 0) begin
      for (int k = 1; k <= 3; k++) begin
        int c;
        c = (m_last + k) % 3;
        if (m_owner < 0 && r[c]) begin
          m_owner = c;
          m_rem = dur[c];
        end
      end
    end else if (!r[m_owner]) begin
      m_last = m_owner; m_owner = -1; m_rem = 0;
    end else if (t && !pz && m_rem > 0) begin
      m_rem = m_rem - 1;
      if (m_rem == 0) m_donep = m_owner;
    end
  endfunction

  function bit [3+3+1+CW-1:0] model_out();
    return {ph_bit(m_owner), ph_bit(m_donep), (m_owner >= 0), CW'(m_rem)};
  endfunction

  // One clock: drive inputs, take the edge, advance the reference, settle.
  task cyc(input bit [2:0] r, input bit t, input bit p, input bit rst);
    bus.req = r;
    bus.tick_en = t;
`ifdef PHASE_TIMER_PAUSE_EN
    bus.pause = p;
`endif
    nRESET = !rst;
    @(posedge CLK);
    #1;
    model_step(r, t, p, rst);
  endtask

  task test_reset();
    cyc(3'b000, 1'b0, 1'b0, 1'b1);
    cyc(3'b000, 1'b1, 1'b0, 1'b1);
    n_chk++;
    if ({bus.grant, bus.done, bus.busy, bus.remaining} !== '0) begin
      n_fail++;
      $display("FAIL reset_state: grant=%b done=%b busy=%b rem=%0d, want all 0",
               bus.grant, bus.done, bus.busy, bus.remaining);
    end
  endtask

  task test_single_wash();
    bit [2:0] eg [5] = '{3'b001, 3'b001, 3'b001, 3'b001, 3'b000};
    bit [2:0] ed [5] = '{3'b000, 3'b000, 3'b000, 3'b001, 3'b000};
    int       er [5] = '{3, 2, 1, 0, 0};
    cyc(3'b000, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      cyc((i < 4) ? 3'b001 : 3'b000, 1'b1, 1'b0, 1'b0);
      n_chk++;
      if (bus.grant !== eg[i] || bus.done !== ed[i] || bus.remaining !== CW'(er[i])) begin
        n_fail++;
        $display("FAIL single_wash[%0d]: grant=%b done=%b rem=%0d, want grant=%b done=%b rem=%0d",
                 i, bus.grant, bus.done, bus.remaining, eg[i], ed[i], er[i]);
      end
    end
  endtask

  task test_round_robin();
    bit [2:0] want [4] = '{3'b001, 3'b010, 3'b100, 3'b001};
    bit [2:0] prev;
    int ng;
    ng = 0;
    prev = '0;
    cyc(3'b000, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 60 && ng < 4; i++) begin
      cyc(3'b111, 1'b1, 1'b0, 1'b0);
      if (bus.grant != 3'b000 && prev == 3'b000) begin
        n_chk++;
        if (bus.grant !== want[ng]) begin
          n_fail++;
          $display("FAIL rr_order[%0d]: grant=%b, want %b", ng, bus.grant, want[ng]);
        end
        ng++;
      end
      if (bus.done != 3'b000) begin
        n_chk++;
        if (bus.done !== bus.grant || $countones(bus.done) != 1) begin
          n_fail++;
          $display("FAIL rr_done_bit: done=%b, want one-hot equal to grant=%b",
                   bus.done, bus.grant);
        end
      end
      prev = bus.grant;
    end
    n_chk++;
    if (ng != 4) begin
      n_fail++;
      $display("FAIL rr_timeout: saw %0d grants, want 4", ng);
    end
  endtask

  task test_abort();
    bit seen_done;
    seen_done = 1'b0;
    cyc(3'b000, 1'b0, 1'b0, 1'b1);
    cyc(3'b010, 1'b1, 1'b0, 1'b0);
    cyc(3'b010, 1'b1, 1'b0, 1'b0);
    n_chk++;
    if (bus.grant !== 3'b010 || bus.remaining !== CW'(1)) begin
      n_fail++;
      $display("FAIL abort_setup: grant=%b rem=%0d, want 010 and 1", bus.grant, bus.remaining);
    end
    cyc(3'b000, 1'b1, 1'b0, 1'b0);
    n_chk++;
    if ({bus.grant, bus.done, bus.busy, bus.remaining} !== '0) begin
      n_fail++;
      $display("FAIL abort_idle: grant=%b done=%b busy=%b rem=%0d, want all 0",
               bus.grant, bus.done, bus.busy, bus.remaining);
    end
    for (int i = 0; i < 4; i++) begin
      cyc(3'b000, 1'b1, 1'b0, 1'b0);
      if (bus.done != 3'b000) seen_done = 1'b1;
    end
    n_chk++;
    if (seen_done) begin
      n_fail++;
      $display("FAIL abort_no_done: done pulsed after abort, want never");
    end
  endtask

  task test_slow_tick();
    int ticks;
    bit got;
    bit granted;
    ticks = 0; got = 1'b0; granted = 1'b0;
    cyc(3'b000, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 40 && !got; i++) begin
      bit t;
      t = (i % 4 == 3);
      if (granted && t) ticks++;
      cyc(3'b100, t, 1'b0, 1'b0);
      if (bus.grant != 3'b000) granted = 1'b1;
      n_chk++;
      if ({bus.grant, bus.done, bus.busy, bus.remaining} !== model_out()) begin
        n_fail++;
        $display("FAIL slow_tick_cyc%0d: got %h, want %h", i,
                 {bus.grant, bus.done, bus.busy, bus.remaining}, model_out());
      end
      if (bus.done != 3'b000) begin
        got = 1'b1;
        n_chk++;
        if (bus.done !== 3'b100 || ticks != 4) begin
          n_fail++;
          $display("FAIL slow_tick_done: done=%b after %0d ticks, want 100 after 4",
                   bus.done, ticks);
        end
      end
    end
    n_chk++;
    if (!got) begin
      n_fail++;
      $display("FAIL slow_tick_timeout: done=0, want one pulse");
    end
    cyc(3'b000, 1'b0, 1'b0, 1'b0);
  endtask

  task test_reset_mid_run();
    cyc(3'b000, 1'b0, 1'b0, 1'b1);
    cyc(3'b001, 1'b1, 1'b0, 1'b0);
    cyc(3'b001, 1'b1, 1'b0, 1'b0);
    n_chk++;
    if (bus.remaining !== CW'(2) || bus.busy !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_mid_setup: rem=%0d busy=%b, want 2 and 1", bus.remaining, bus.busy);
    end
    cyc(3'b001, 1'b1, 1'b0, 1'b1);
    n_chk++;
    if ({bus.grant, bus.done, bus.busy, bus.remaining} !== '0) begin
      n_fail++;
      $display("FAIL rst_mid_idle: grant=%b done=%b busy=%b rem=%0d, want all 0",
               bus.grant, bus.done, bus.busy, bus.remaining);
    end
    cyc(3'b011, 1'b1, 1'b0, 1'b0);
    n_chk++;
    if (bus.grant !== 3'b001 || bus.remaining !== CW'(3)) begin
      n_fail++;
      $display("FAIL rst_mid_regrant: grant=%b rem=%0d, want 001 and 3",
               bus.grant, bus.remaining);
    end
    cyc(3'b000, 1'b0, 1'b0, 1'b0);
  endtask

`ifdef PHASE_TIMER_PAUSE_EN
  task test_pause();
    int wait_n;
    cyc(3'b000, 1'b0, 1'b0, 1'b1);
    cyc(3'b001, 1'b1, 1'b0, 1'b0);
    cyc(3'b001, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      cyc(3'b001, 1'b1, 1'b1, 1'b0);
      n_chk++;
      if (bus.remaining !== CW'(2) || bus.grant !== 3'b001 || bus.busy !== 1'b1) begin
        n_fail++;
        $display("FAIL pause_hold[%0d]: rem=%0d grant=%b busy=%b, want 2 001 1",
                 i, bus.remaining, bus.grant, bus.busy);
      end
    end
    wait_n = 0;
    for (int i = 0; i < 6 && bus.done == 3'b000; i++) begin
      cyc(3'b001, 1'b1, 1'b0, 1'b0);
      wait_n++;
    end
    n_chk++;
    if (bus.done !== 3'b001 || wait_n != 2) begin
      n_fail++;
      $display("FAIL pause_resume: done=%b after %0d ticks, want 001 after 2", bus.done, wait_n);
    end
    cyc(3'b000, 1'b0, 1'b0, 1'b0);
  endtask
`endif

  task test_random();
    bit [2:0] r;
    r = '0;
    cyc(3'b000, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 800; i++) begin
      bit t, p, rst;
      if ($urandom_range(0, 9) == 0) r = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 29) == 0) r = r & ~3'($urandom_range(0, 7));
      t = ($urandom_range(0, 2) != 0);
      p = ($urandom_range(0, 4) == 0);
      rst = ($urandom_range(0, 199) == 0);
      cyc(r, t, p, rst);
      n_chk++;
      if ({bus.grant, bus.done, bus.busy, bus.remaining} !== model_out()) begin
        n_fail++;
        $display("FAIL random_cyc%0d: grant=%b done=%b busy=%b rem=%0d, want %b %b %b %0d",
                 i, bus.grant, bus.done, bus.busy, bus.remaining,
                 ph_bit(m_owner), ph_bit(m_donep), (m_owner >= 0), m_rem);
      end
    end
  endtask

  initial begin
    bus.req = '0;
    bus.tick_en = 1'b0;
`ifdef PHASE_TIMER_PAUSE_EN
    bus.pause = 1'b0;
`endif
    test_reset();
    test_single_wash();
    test_round_robin();
    test_abort();
    test_slow_tick();
    test_reset_mid_run();
`ifdef PHASE_TIMER_PAUSE_EN
    test_pause();
`endif
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
